seq_mult_param: RTL and testbench

//  Parametrised iterative shift-add multiplier; successor of the fixed 32-bit unit.

---
 rtl/seq_mult_param.sv | 106 ++++++++++
 tb/tb_seq_mult_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier, WIDTH-bit signed/unsigned operands,
// 2*WIDTH-bit product, optional early exit once the multiplier runs out of ones.
module seq_mult_param #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               end_mul,
    output logic [2*WIDTH-1:0] produto
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] produto_q, produto_d;
    logic               end_mul_q, end_mul_d;
    logic [2*WIDTH-1:0] addend;
    logic               last;

    always_comb begin
        state_d   = state_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        produto_d = produto_q;
        end_mul_d = 1'b0;
        addend    = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;
        // Final iteration: full count reached, or no multiplier ones left above bit 0
        last      = (cnt_q == CW'(WIDTH - 1)) ||
                    (EARLY_EXIT && (mag_b_q[WIDTH-1:1] == '0));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mag_a_d = (signed_mode && A[WIDTH-1]) ? -A : A;
                    mag_b_d = (signed_mode && B[WIDTH-1]) ? -B : B;
                    neg_d   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (mag_b_q[0]) begin
                    acc_d = acc_q + addend;
                end
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                produto_d = neg_q ? -acc_q : acc_q;
                end_mul_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            produto_q <= '0;
            end_mul_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            produto_q <= produto_d;
            end_mul_q <= end_mul_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign end_mul = end_mul_q;
    assign produto = produto_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: 32-bit full-latency unit and
// 8-bit early-exit unit sharing one clock.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        s32, sm32, busy32, em32;
    logic [31:0] a32, b32;
    logic [63:0] p32;
    logic        s8, sm8, busy8, em8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(32), .EARLY_EXIT(1'b0)) u32 (
        .clock(clk), .reset(rst), .start(s32), .signed_mode(sm32),
        .A(a32), .B(b32), .busy(busy32), .end_mul(em32), .produto(p32)
    );

    seq_mult_param #(.WIDTH(8), .EARLY_EXIT(1'b1)) u8 (
        .clock(clk), .reset(rst), .start(s8), .signed_mode(sm8),
        .A(a8), .B(b8), .busy(busy8), .end_mul(em8), .produto(p8)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start at the next edge (edge 0); n = edges after edge 0 until end_mul
    task automatic op32(input logic [31:0] a, input logic [31:0] b,
                        input logic sm, output int n);
        s32 = 1'b1; a32 = a; b32 = b; sm32 = sm;
        tick();
        s32 = 1'b0;
        n = 0;
        while (!em32 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic sm, output int n);
        s8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
        tick();
        s8 = 1'b0;
        n = 0;
        while (!em8 && n < 15) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          n;
        int          pulses;
        bit          ok;
        logic [7:0]  ra, rb, mb;
        logic        rs;
        int          ia, ib, k;
        logic [31:0] prod;

        rst = 1'b1;
        s32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
        s8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_end", 64'(em32), 64'd0);
        chk("rst_prod", p32, 64'd0);
        chk("rst_prod8", 64'(p8), 64'd0);

        // Unsigned 3*5 with per-edge busy tracking
        s32 = 1'b1; a32 = 32'd3; b32 = 32'd5; sm32 = 1'b0;
        tick();
        s32 = 1'b0;
        chk("t1_busy_e0", 64'(busy32), 64'd1);
        ok = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (!busy32 || em32) ok = 1'b0;
        end
        chk("t1_busy_e1_32", 64'(ok), 64'd1);
        tick();
        chk("t1_end_e33", 64'(em32), 64'd1);
        chk("t1_prod", p32, 64'd15);
        chk("t1_idle_e33", 64'(busy32), 64'd0);
        tick();
        chk("t1_end_pulse", 64'(em32), 64'd0);
        chk("t1_hold", p32, 64'd15);

        op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, n);
        chk("t2_lat", 64'(n), 64'd33);
        chk("t2_umax", p32, 64'hFFFFFFFE_00000001);
        op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, n);
        chk("t2_sneg1", p32, 64'h1);
        op32(32'h80000000, 32'h80000000, 1'b1, n);
        chk("t3_minmin", p32, 64'h4000000000000000);
        op32(32'h80000000, 32'h1, 1'b1, n);
        chk("t3_min1", p32, 64'hFFFFFFFF80000000);
        op32(32'hFFFFFFFD, 32'd7, 1'b1, n);
        chk("t3_m3x7", p32, 64'hFFFFFFFF_FFFFFFEB);
        op32(32'hFFFFFFFD, 32'd7, 1'b0, n);
        chk("t3_u_m3x7", p32, 64'h00000006_FFFFFFEB);

        // Starts during CALC are ignored; start in end_mul cycle is taken
        s32 = 1'b1; a32 = 32'd7; b32 = 32'd9; sm32 = 1'b0;
        tick();
        pulses = 0;
        for (int e = 1; e <= 33; e++) begin
            s32 = (e == 5 || e == 20);
            a32 = 32'd100; b32 = 32'd100; sm32 = 1'b1;
            tick();
            if (em32) pulses++;
        end
        chk("t4_one_end", 64'(pulses), 64'd1);
        chk("t4_end_e33", 64'(em32), 64'd1);
        chk("t4_prod", p32, 64'd63);
        op32(32'd2, 32'd3, 1'b0, n);
        chk("t4_b2b_lat", 64'(n), 64'd33);
        chk("t4_b2b_prod", p32, 64'd6);

        // Reset mid-operation
        s32 = 1'b1; a32 = 32'd11; b32 = 32'd13; sm32 = 1'b0;
        tick();
        s32 = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 64'(busy32), 64'd0);
        chk("t5_end", 64'(em32), 64'd0);
        chk("t5_prod", p32, 64'd0);
        pulses = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (em32 || busy32) pulses++;
        end
        chk("t5_quiet", 64'(pulses), 64'd0);

        // 8-bit early exit
        op8(8'd5, 8'd0, 1'b0, n);
        chk("t6_b0_lat", 64'(n), 64'd2);
        chk("t6_b0_prod", 64'(p8), 64'd0);
        op8(8'h07, 8'h03, 1'b0, n);
        chk("t6_b3_lat", 64'(n), 64'd3);
        chk("t6_b3_prod", 64'(p8), 64'd21);
        op8(8'h80, 8'h80, 1'b1, n);
        chk("t6_minmin_lat", 64'(n), 64'd9);
        chk("t6_minmin", 64'(p8), 64'h4000);
        op8(8'hFF, 8'hFF, 1'b0, n);
        chk("t6_umax", 64'(p8), 64'hFE01);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            ia = rs ? int'($signed(ra)) : int'(ra);
            ib = rs ? int'($signed(rb)) : int'(rb);
            prod = 32'(ia * ib);
            mb = (rs && rb[7]) ? 8'(-rb) : rb;
            k = 1;
            for (int j = 0; j < 8; j++) if (mb[j]) k = j + 1;
            op8(ra, rb, rs, n);
            chk($sformatf("t6_rnd%0d_lat", i), 64'(n), 64'(k + 1));
            chk($sformatf("t6_rnd%0d_prod", i), 64'(p8), 64'(prod[15:0]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
